// File: rtl/hv_pkg.sv
// Shared types, default geometry and geometry helpers for the HV result
// collector / AXI-Stream emitter.
package hv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_OUT_W     = 64;
    localparam int DEF_NUM_CORES = 8;
    localparam int DEF_CNT_W     = 16;

    // Lanes per beat and beats per group for the default geometry.
    localparam int LANES = DEF_OUT_W / DEF_DATA_W;
    localparam int BEATS = DEF_NUM_CORES / LANES;

    function automatic int calc_lanes(input int out_w, input int data_w);
        return out_w / data_w;
    endfunction

    function automatic int calc_beats(input int num_cores, input int out_w, input int data_w);
        return num_cores / (out_w / data_w);
    endfunction

    // Beat-select width; kept at least one bit so single-beat groups still
    // have a legal index register.
    function automatic int calc_sel_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // A beat must hold a whole number of cores and a group a whole number
    // of beats.
    function automatic bit cfg_ok(input int data_w, input int out_w, input int num_cores);
        return (data_w > 0) && (out_w >= data_w) && (out_w % data_w == 0) &&
               (num_cores > 0) && (num_cores % (out_w / data_w) == 0);
    endfunction

endpackage

// File: rtl/hv_dst_stream_if.sv
// AXI-Stream master-side bundle for the HV result emitter.
interface hv_dst_stream_if #(
    parameter int OUT_W = 64
);
    logic               m_tvalid;
    logic               m_tready;
    logic [OUT_W-1:0]   m_tdata;
    logic [OUT_W/8-1:0] m_tstrb;
    logic               m_tlast;

    modport master (
        output m_tvalid, m_tdata, m_tstrb, m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tvalid, m_tdata, m_tstrb, m_tlast,
        output m_tready
    );
endinterface

// File: rtl/hv_bank_buf.sv
// One ping-pong bank: holds a full group of core results, its full flag,
// and selects one OUT_W beat for the stream side.
module hv_bank_buf
    import hv_pkg::*;
#(
    parameter int  DATA_W    = DEF_DATA_W,
    parameter int  OUT_W     = DEF_OUT_W,
    parameter int  NUM_CORES = DEF_NUM_CORES,
    localparam int NBEATS    = calc_beats(NUM_CORES, OUT_W, DATA_W),
    localparam int SEL_W     = calc_sel_w(NBEATS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        wr_en,
    input  logic [NUM_CORES*DATA_W-1:0] wr_data,
    input  logic                        rd_clr,
    input  logic [SEL_W-1:0]            beat_sel,
    output logic                        full,
    output logic [OUT_W-1:0]            rd_data
);

    // Core c sits at bits [c*DATA_W +: DATA_W], so beat k (cores
    // k*LANES .. k*LANES+LANES-1) is simply the k-th OUT_W slice.
    logic [NBEATS-1:0][OUT_W-1:0] mem;

    // Capture a group only into an empty bank; flush wins over set/clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem  <= '0;
            full <= 1'b0;
        end else begin
            if (wr_en && !full) begin
                mem <= wr_data;
            end
            if (flush) begin
                full <= 1'b0;
            end else if (wr_en && !full) begin
                full <= 1'b1;
            end else if (rd_clr) begin
                full <= 1'b0;
            end
        end
    end

    if (NBEATS == 1) begin : g_one
        assign rd_data = mem[0];
    end else begin : g_mux
        assign rd_data = mem[beat_sel];
    end

endmodule

// File: rtl/hv_dst_stream.sv
// HV accelerator output path: captures NUM_CORES results per update into a
// two-bank ping-pong buffer and emits them as OUT_W AXI-Stream beats, with
// TLAST on the final beat of a run.
module hv_dst_stream
    import hv_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_groups,
    input  logic                        res_valid,
    input  logic [NUM_CORES*DATA_W-1:0] res_data,
    output logic                        res_ready,
    hv_dst_stream_if.master             m_axis,
    output logic                        busy,
    output logic                        done,
    output logic                        ovf
);

    localparam int NBEATS = calc_beats(NUM_CORES, OUT_W, DATA_W);
    localparam int SEL_W  = calc_sel_w(NBEATS);

    if (!cfg_ok(DATA_W, OUT_W, NUM_CORES)) begin : g_cfg_err
        $error("hv_dst_stream: OUT_W must be a multiple of DATA_W and NUM_CORES of OUT_W/DATA_W");
    end

    state_t           state;
    logic [CNT_W-1:0] ng_q;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] drn_cnt;
    logic             wb;
    logic             rb;
    logic [SEL_W-1:0] beat_idx;
    logic             done_q;
    logic             ovf_q;

    logic [1:0]            full;
    logic [1:0]            wr_en;
    logic [1:0]            rd_clr;
    logic [1:0][OUT_W-1:0] rd_data;

    logic run, launch, cap, tvalid, hs, last_beat, last_grp, rel;

    assign run       = (state == RUN);
    assign launch    = (state == IDLE) && start;
    assign res_ready = run && !full[wb] && (acc_cnt < ng_q);
    assign cap       = res_valid && res_ready;
    assign tvalid    = full[rb];
    assign hs        = tvalid && m_axis.m_tready;
    assign last_beat = (beat_idx == SEL_W'(NBEATS - 1));
    assign last_grp  = (drn_cnt == ng_q - CNT_W'(1));
    assign rel       = hs && last_beat;

    // Two banks; the write pointer steers captures, the read pointer
    // releases a bank once its last beat has been taken.
    for (genvar i = 0; i < 2; i++) begin : g_bank
        assign wr_en[i]  = cap && (wb == 1'(i));
        assign rd_clr[i] = rel && (rb == 1'(i));

        hv_bank_buf #(
            .DATA_W    (DATA_W),
            .OUT_W     (OUT_W),
            .NUM_CORES (NUM_CORES)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .flush    (launch),
            .wr_en    (wr_en[i]),
            .wr_data  (res_data),
            .rd_clr   (rd_clr[i]),
            .beat_sel (beat_idx),
            .full     (full[i]),
            .rd_data  (rd_data[i])
        );
    end

    // Stream outputs come straight from registers and bank contents, so they
    // hold steady while the sink stalls.
    assign m_axis.m_tvalid = tvalid;
    assign m_axis.m_tdata  = rd_data[rb];
    assign m_axis.m_tstrb  = '1;
    assign m_axis.m_tlast  = tvalid && last_beat && last_grp;

    assign busy = run;
    assign done = done_q;
    assign ovf  = ovf_q;

    // Run control: start/length latch, capture and drain pointers/counters,
    // overflow flag and end-of-run pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ng_q     <= '0;
            acc_cnt  <= '0;
            drn_cnt  <= '0;
            wb       <= 1'b0;
            rb       <= 1'b0;
            beat_idx <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ovf_q    <= 1'b0;
                        acc_cnt  <= '0;
                        drn_cnt  <= '0;
                        beat_idx <= '0;
                        wb       <= 1'b0;
                        rb       <= 1'b0;
                        ng_q     <= num_groups;
                        if (num_groups == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (cap) begin
                        wb      <= ~wb;
                        acc_cnt <= acc_cnt + CNT_W'(1);
                    end
                    if (res_valid && !res_ready) begin
                        ovf_q <= 1'b1;
                    end
                    if (hs) begin
                        if (last_beat) begin
                            beat_idx <= '0;
                            rb       <= ~rb;
                            drn_cnt  <= drn_cnt + CNT_W'(1);
                            if (last_grp) begin
                                state  <= IDLE;
                                done_q <= 1'b1;
                            end
                        end else begin
                            beat_idx <= beat_idx + SEL_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hv_dst_stream.sv
// Directed bench for hv_dst_stream: default geometry plus a 16-bit,
// single-beat-per-group instance.
module tb_hv_dst_stream;
    import hv_pkg::*;

    int total = 0;
    int bad   = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  num_groups = '0;
    logic         res_valid = 1'b0;
    logic [255:0] res_data = '0;
    logic         res_ready, busy, done, ovf;

    logic         start_b = 1'b0;
    logic [15:0]  ng_b = '0;
    logic         rv_b = 1'b0;
    logic [63:0]  rd_b = '0;
    logic         rr_b, busy_b, done_b, ovf_b;

    hv_dst_stream_if #(.OUT_W(64)) ax ();
    hv_dst_stream_if #(.OUT_W(64)) ax_b ();

    always #5 clk = ~clk;

    hv_dst_stream #(.DATA_W(32), .OUT_W(64), .NUM_CORES(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_groups(num_groups),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .m_axis(ax), .busy(busy), .done(done), .ovf(ovf)
    );

    hv_dst_stream #(.DATA_W(16), .OUT_W(64), .NUM_CORES(4), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .num_groups(ng_b),
        .res_valid(rv_b), .res_data(rd_b), .res_ready(rr_b),
        .m_axis(ax_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Group whose core c holds base + c.
    function automatic logic [255:0] mk_data(input logic [31:0] base);
        logic [255:0] d;
        for (int c = 0; c < 8; c++) d[c*32 +: 32] = base + 32'(c);
        return d;
    endfunction

    // Beat k carries cores 2k (low lane) and 2k+1 (high lane).
    function automatic logic [63:0] beat_of(input logic [31:0] base, input int k);
        return {base + 32'(2*k + 1), base + 32'(2*k)};
    endfunction

    task automatic chk_reset(input string p);
        chk({p, "_tvalid"}, ax.m_tvalid, 1'b0);
        chk({p, "_tdata"},  ax.m_tdata, 64'h0);
        chk({p, "_tlast"},  ax.m_tlast, 1'b0);
        chk({p, "_tstrb"},  ax.m_tstrb, 8'hFF);
        chk({p, "_busy"},   busy, 1'b0);
        chk({p, "_done"},   done, 1'b0);
        chk({p, "_ovf"},    ovf, 1'b0);
        chk({p, "_ready"},  res_ready, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] q[$];
        logic [63:0] held;
        logic [63:0] exp_beat;
        logic        rdy;
        bit          hold;
        bit          seen_done;
        int          fed;
        int          beats;
        int          lasts;

        ax.m_tready   = 1'b0;
        ax_b.m_tready = 1'b0;
        step();
        step();
        chk_reset("rst0");
        chk("rst0_b_tvalid", ax_b.m_tvalid, 1'b0);
        rst = 1'b0;

        // ---- T1: one group, sink always ready
        start = 1'b1; num_groups = 16'd1;
        step();
        start = 1'b0;
        chk("t1_busy", busy, 1'b1);
        chk("t1_ready", res_ready, 1'b1);
        res_valid = 1'b1; res_data = mk_data(32'd1); ax.m_tready = 1'b1;
        step();
        res_valid = 1'b0;
        chk("t1_ready_low", res_ready, 1'b0);
        chk("t1_first_beat", ax.m_tdata, 64'h00000002_00000001);
        for (int k = 0; k < 4; k++) begin
            chk("t1_tvalid", ax.m_tvalid, 1'b1);
            chk("t1_tdata", ax.m_tdata, beat_of(32'd1, k));
            chk("t1_tlast", ax.m_tlast, k == 3);
            if (k == 3) chk("t1_last_beat", ax.m_tdata, 64'h00000008_00000007);
            step();
        end
        chk("t1_done", done, 1'b1);
        chk("t1_busy_off", busy, 1'b0);
        chk("t1_tvalid_off", ax.m_tvalid, 1'b0);
        step();
        chk("t1_done_pulse", done, 1'b0);

        // ---- T2: three groups, sink stalled, third update overflows
        ax.m_tready = 1'b0;
        start = 1'b1; num_groups = 16'd3;
        step();
        start = 1'b0;
        res_valid = 1'b1; res_data = mk_data(32'h100);
        step();
        res_valid = 1'b0;
        step();
        res_valid = 1'b1; res_data = mk_data(32'h200);
        step();
        res_valid = 1'b0;
        chk("t2_ready_low", res_ready, 1'b0);
        step();
        chk("t2_ovf_pre", ovf, 1'b0);
        res_valid = 1'b1; res_data = mk_data(32'h300);
        step();
        res_valid = 1'b0;
        chk("t2_ovf", ovf, 1'b1);
        chk("t2_hold_valid", ax.m_tvalid, 1'b1);
        chk("t2_hold_data", ax.m_tdata, beat_of(32'h100, 0));
        ax.m_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t2_tvalid", ax.m_tvalid, 1'b1);
            chk("t2_tdata", ax.m_tdata, beat_of(k < 4 ? 32'h100 : 32'h200, k % 4));
            chk("t2_tlast", ax.m_tlast, 1'b0);
            step();
        end
        chk("t2_drained", ax.m_tvalid, 1'b0);
        chk("t2_ready_again", res_ready, 1'b1);
        res_valid = 1'b1; res_data = mk_data(32'h400);
        step();
        res_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t2c_tdata", ax.m_tdata, beat_of(32'h400, k));
            chk("t2c_tlast", ax.m_tlast, k == 3);
            step();
        end
        chk("t2_done", done, 1'b1);
        chk("t2_ovf_sticky", ovf, 1'b1);

        // ---- T3: five groups, random sink stalls, scoreboard
        ax.m_tready = 1'b0;
        start = 1'b1; num_groups = 16'd5;
        step();
        start = 1'b0;
        chk("t3_ovf_cleared", ovf, 1'b0);
        fed = 0; beats = 0; lasts = 0; hold = 1'b0; seen_done = 1'b0; held = '0;
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            if (hold) begin
                chk("t3_stall_valid", ax.m_tvalid, 1'b1);
                chk("t3_stall_data", ax.m_tdata, held);
            end
            rdy = 1'($urandom_range(0, 1));
            ax.m_tready = rdy;
            if (ax.m_tvalid && rdy) begin
                exp_beat = (q.size() > 0) ? q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                chk("t3_tdata", ax.m_tdata, exp_beat);
                chk("t3_tlast", ax.m_tlast, beats == 19);
                if (ax.m_tlast) lasts++;
                beats++;
            end
            if (res_ready && fed < 5) begin
                res_valid = 1'b1;
                res_data  = mk_data(32'hA000_0000 + 32'(fed * 256));
                for (int k = 0; k < 4; k++) q.push_back(beat_of(32'hA000_0000 + 32'(fed * 256), k));
                fed++;
            end else begin
                res_valid = 1'b0;
            end
            hold = ax.m_tvalid && !rdy;
            held = ax.m_tdata;
            step();
            if (done) seen_done = 1'b1;
        end
        res_valid = 1'b0;
        chk("t3_done_seen", seen_done, 1'b1);
        chk("t3_beats", beats, 20);
        chk("t3_lasts", lasts, 1);
        chk("t3_queue_empty", q.size(), 0);
        chk("t3_ovf", ovf, 1'b0);

        // ---- T4: zero-length run
        ax.m_tready = 1'b1;
        step();
        start = 1'b1; num_groups = 16'd0;
        step();
        start = 1'b0;
        chk("t4_done", done, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_tvalid", ax.m_tvalid, 1'b0);
        step();
        chk("t4_done_pulse", done, 1'b0);
        chk("t4_tvalid2", ax.m_tvalid, 1'b0);

        // ---- T5: reset during beat 2 of group 1, then a clean run
        ax.m_tready = 1'b0;
        start = 1'b1; num_groups = 16'd2;
        step();
        start = 1'b0;
        res_valid = 1'b1; res_data = mk_data(32'h500);
        step();
        res_data = mk_data(32'h600);
        step();
        res_data = mk_data(32'h700);
        step();
        res_valid = 1'b0;
        chk("t5_ovf", ovf, 1'b1);
        ax.m_tready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("t5_g1b2", ax.m_tdata, beat_of(32'h600, 2));
        rst = 1'b1;
        step();
        chk_reset("t5_rst");
        rst = 1'b0;
        start = 1'b1; num_groups = 16'd1;
        step();
        start = 1'b0;
        chk("t5_ovf_clean", ovf, 1'b0);
        chk("t5_busy", busy, 1'b1);
        res_valid = 1'b1; res_data = mk_data(32'h800);
        step();
        res_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t5_tdata", ax.m_tdata, beat_of(32'h800, k));
            chk("t5_tlast", ax.m_tlast, k == 3);
            step();
        end
        chk("t5_done", done, 1'b1);

        // ---- T6: 16-bit cores, one beat per group
        ax_b.m_tready = 1'b1;
        start_b = 1'b1; ng_b = 16'd1;
        step();
        start_b = 1'b0;
        chk("t6_ready", rr_b, 1'b1);
        rv_b = 1'b1; rd_b = 64'h4444_3333_2222_1111;
        step();
        rv_b = 1'b0;
        chk("t6_tvalid", ax_b.m_tvalid, 1'b1);
        chk("t6_tdata", ax_b.m_tdata, 64'h4444_3333_2222_1111);
        chk("t6_tlast", ax_b.m_tlast, 1'b1);
        chk("t6_ready_low", rr_b, 1'b0);
        step();
        chk("t6_done", done_b, 1'b1);
        chk("t6_tvalid_off", ax_b.m_tvalid, 1'b0);
        chk("t6_busy", busy_b, 1'b0);
        chk("t6_ovf", ovf_b, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
